// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Combinational fetch-stage lookup, EX-stage update/mispredict, saturating stats and a debug read port.
module branch_predictor #(
  parameter  int XLEN    = 32,
  parameter  int ENTRIES = 16,
  parameter  int TAG_W   = 8,
  parameter  int CTR_W   = 2,
  parameter  int PC_LSB  = 2,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             flush,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [XLEN-1:0]  dbg_entry,
  output logic [31:0]      stat_br,
  output logic [31:0]      stat_miss
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam int               DBG_W   = 2 + CTR_W + TAG_W;

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_is_jump;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];
  logic [31:0]        r_stat_br;
  logic [31:0]        r_stat_miss;

  logic [IDX_W-1:0]   w_if_idx;
  logic [TAG_W-1:0]   w_if_tag;
  logic [IDX_W-1:0]   w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd_hit;
  logic [DBG_W-1:0]   w_dbg;

  assign w_if_idx  = if_pc[PC_LSB +: IDX_W];
  assign w_if_tag  = if_pc[PC_LSB + IDX_W +: TAG_W];
  assign w_upd_idx = upd_pc[PC_LSB +: IDX_W];
  assign w_upd_tag = upd_pc[PC_LSB + IDX_W +: TAG_W];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign pred_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = pred_hit && (r_is_jump[w_if_idx] || r_ctr[w_if_idx][CTR_W-1]);
  assign pred_target = pred_taken ? r_target[w_if_idx] : if_pc + XLEN'(4);

  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  assign w_dbg     = {r_valid[dbg_idx], r_is_jump[dbg_idx], r_ctr[dbg_idx], r_tag[dbg_idx]};
  assign dbg_entry = XLEN'(w_dbg);
  assign stat_br   = r_stat_br;
  assign stat_miss = r_stat_miss;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= '0;
      r_is_jump <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (flush) begin
      // Flush wins over any update; counters deliberately survive.
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_is_jump) begin
          r_ctr[w_upd_idx]     <= CTR_MAX;
          r_target[w_upd_idx]  <= upd_target;
          r_is_jump[w_upd_idx] <= 1'b1;
        end else if (upd_taken) begin
          if (r_ctr[w_upd_idx] != CTR_MAX) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 1'b1;
          r_target[w_upd_idx] <= upd_target;
        end else if (r_ctr[w_upd_idx] != '0) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 1'b1;
        end
      end else if (upd_taken) begin
        r_valid[w_upd_idx]   <= 1'b1;
        r_tag[w_upd_idx]     <= w_upd_tag;
        r_target[w_upd_idx]  <= upd_target;
        r_is_jump[w_upd_idx] <= upd_is_jump;
        r_ctr[w_upd_idx]     <= upd_is_jump ? CTR_MAX : CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_br   <= '0;
      r_stat_miss <= '0;
    end else begin
      if (upd_valid && (r_stat_br != 32'hFFFF_FFFF)) r_stat_br <= r_stat_br + 32'd1;
      if (mispredict && (r_stat_miss != 32'hFFFF_FFFF)) r_stat_miss <= r_stat_miss + 32'd1;
    end
  end

endmodule
